// File: rtl/uart_tx_word_sequencer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_word_sequencer_if
// Groups the word-source handshake, the transmitter write/busy handshake,
// the status pulses and the FSM debug view of uart_tx_word_sequencer.
//
// Handshake semantics:
//   word_valid/word_ready: a word transfers on the rising edge where both are
//   1. word_ready is 1 only while the sequencer is idle. A source that sees
//   word_ready=0 must keep word_valid and word_in steady; nothing is queued.
//   tx_wr/tx_busy: tx_wr is a single-cycle write strobe. It is only issued
//   while tx_busy=0, and tx_data is stable in that cycle.
//
// Signals:
//   word_in[15:0]  word to send, [15:8] first       (source -> sequencer)
//   word_valid     source offers word_in            (source -> sequencer)
//   word_ready     sequencer idle, can take a word  (sequencer -> source)
//   tx_data[7:0]   byte for the transmitter         (sequencer -> transmitter)
//   tx_wr          write strobe                     (sequencer -> transmitter)
//   tx_busy        transmitter sending a frame      (transmitter -> sequencer)
//   done           pulse: both bytes sent
//   timeout_err    pulse: sequence aborted on timeout
//   state_dbg[3:0] current FSM state encoding
//
// Modports: master = the sequencer, slave = its environment.
// ---------------------------------------------------------------------------
interface uart_tx_word_sequencer_if;
  logic [15:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        done;
  logic        timeout_err;
  logic [3:0]  state_dbg;

  modport master (
    input  word_in, word_valid, tx_busy,
    output word_ready, tx_data, tx_wr, done, timeout_err, state_dbg
  );

  modport slave (
    output word_in, word_valid, tx_busy,
    input  word_ready, tx_data, tx_wr, done, timeout_err, state_dbg
  );
endinterface

// File: rtl/uart_tx_word_sequencer.sv
// ---------------------------------------------------------------------------
// uart_tx_word_sequencer
// Sends one 16-bit word to a byte-wide UART transmitter as two frames, high
// byte first, with an idle gap of GAP_CYCLES between them. Aborts with a
// timeout_err pulse if the transmitter never raises tx_busy after a write
// (ACK_TIMEOUT) or keeps it high too long (BUSY_TIMEOUT).
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    uart_tx_word_sequencer_if.master (word handshake, tx handshake,
//          done/timeout_err pulses, state_dbg)
// ---------------------------------------------------------------------------
module uart_tx_word_sequencer #(
  parameter int GAP_CYCLES   = 16,
  parameter int ACK_TIMEOUT  = 8,
  parameter int BUSY_TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  uart_tx_word_sequencer_if.master   bus
);

  localparam int CNT_MAX_A = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > BUSY_TIMEOUT) ? CNT_MAX_A : BUSY_TIMEOUT;
  localparam int CW        = $clog2(CNT_MAX) + 1;

  // Terminal counts: the counter is 0 in the first cycle of a state, so the
  // N-th cycle of a state sees N-1.
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD_HI = 4'd1,
    ACK_HI  = 4'd2,
    WAIT_HI = 4'd3,
    GAP     = 4'd4,
    LOAD_LO = 4'd5,
    ACK_LO  = 4'd6,
    WAIT_LO = 4'd7,
    DONE    = 4'd8
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    lo_byte_q;
  logic [7:0]    tx_data_q;
  logic          take;
  logic          wr;
  logic          done_p;
  logic          err_p;

  assign take = (state == IDLE) && bus.word_valid;

  // Next state and pulse outputs. Timeouts are flagged in the last allowed
  // cycle of ACK/WAIT, and the FSM returns straight to IDLE.
  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    done_p    = 1'b0;
    err_p     = 1'b0;
    unique case (state)
      IDLE:    if (bus.word_valid) state_nxt = LOAD_HI;
      LOAD_HI: if (!bus.tx_busy) begin
                 wr        = 1'b1;
                 state_nxt = ACK_HI;
               end
      ACK_HI:  if (bus.tx_busy)          state_nxt = WAIT_HI;
               else if (cnt == ACK_LAST) begin
                 err_p     = 1'b1;
                 state_nxt = IDLE;
               end
      WAIT_HI: if (!bus.tx_busy)         state_nxt = GAP;
               else if (cnt == BUSY_LAST) begin
                 err_p     = 1'b1;
                 state_nxt = IDLE;
               end
      GAP:     if (cnt == GAP_LAST)      state_nxt = LOAD_LO;
      LOAD_LO: if (!bus.tx_busy) begin
                 wr        = 1'b1;
                 state_nxt = ACK_LO;
               end
      ACK_LO:  if (bus.tx_busy)          state_nxt = WAIT_LO;
               else if (cnt == ACK_LAST) begin
                 err_p     = 1'b1;
                 state_nxt = IDLE;
               end
      WAIT_LO: if (!bus.tx_busy)         state_nxt = DONE;
               else if (cnt == BUSY_LAST) begin
                 err_p     = 1'b1;
                 state_nxt = IDLE;
               end
      DONE: begin
        done_p    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Per-state cycle counter: restarts on every state change, saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The high byte goes straight to tx_data on accept; only the low byte
  // needs to be kept until the gap ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_byte_q <= 8'h00;
      tx_data_q <= 8'h00;
    end else begin
      if (take) begin
        lo_byte_q <= bus.word_in[7:0];
        tx_data_q <= bus.word_in[15:8];
      end else if (state == GAP && state_nxt == LOAD_LO) begin
        tx_data_q <= lo_byte_q;
      end
    end
  end

  assign bus.word_ready  = (state == IDLE);
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_wr       = wr;
  assign bus.done        = done_p;
  assign bus.timeout_err = err_p;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_uart_tx_word_sequencer.sv
module tb_uart_tx_word_sequencer;

  localparam int GAP_CYCLES   = 16;
  localparam int ACK_TIMEOUT  = 8;
  localparam int BUSY_TIMEOUT = 32;
  localparam int BUSY_LEN     = 10;

  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_HOLD   = 2;
  localparam int M_STUCK  = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx_word_sequencer_if ifc ();

  uart_tx_word_sequencer #(
    .GAP_CYCLES   (GAP_CYCLES),
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  // ---------------- transmitter model ----------------
  // Busy starts the cycle after tx_wr and lasts BUSY_LEN cycles (normal).
  int tx_mode;
  int busy_left;
  int stuck_wrs;
  logic wr_now;

  always @(posedge clk) begin
    wr_now = ifc.tx_wr;
    #1;
    case (tx_mode)
      M_NORMAL: begin
        stuck_wrs = 0;
        if (wr_now) busy_left = BUSY_LEN;
        else if (busy_left > 0) busy_left--;
        ifc.tx_busy = (busy_left > 0);
      end
      M_NEVER: begin
        busy_left = 0;
        ifc.tx_busy = 1'b0;
      end
      M_HOLD: begin
        busy_left = 0;
        ifc.tx_busy = 1'b1;
      end
      default: begin
        if (wr_now) stuck_wrs++;
        if (wr_now && stuck_wrs == 1) busy_left = BUSY_LEN;
        else if (busy_left > 0) busy_left--;
        ifc.tx_busy = (stuck_wrs >= 2) || (busy_left > 0);
      end
    endcase
  end

  // ---------------- monitor ----------------
  logic [7:0] wr_data_q[$];
  int         wr_cyc_q[$];
  int         gap_q[$];
  int         acc_q[$];
  int         done_q[$];
  int         err_q[$];
  int         last_busy_cyc;
  int         both_cnt;

  always @(negedge clk) begin
    if (reset) begin
      if (ifc.tx_wr) begin
        wr_data_q.push_back(ifc.tx_data);
        wr_cyc_q.push_back(cyc);
        gap_q.push_back(cyc - last_busy_cyc - 1);
      end
      if (ifc.word_valid && ifc.word_ready) acc_q.push_back(cyc);
      if (ifc.done) done_q.push_back(cyc);
      if (ifc.timeout_err) err_q.push_back(cyc);
      if (ifc.done && ifc.timeout_err) both_cnt++;
      if (ifc.tx_busy) last_busy_cyc = cyc;
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare bytes written since index base against the expected queue.
  task automatic check_bytes(input string tag, input int base);
    int n;
    n = exp_q.size();
    check({tag, " nbytes"}, wr_data_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < wr_data_q.size())
        check($sformatf("%s byte%0d", tag, i), wr_data_q[base + i], exp_q[i]);
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    ifc.word_valid = 1'b0;
    ifc.word_in    = 16'h0000;
  endtask

  // Offer a word until accepted, then drop valid and scramble word_in.
  // Returns in the cycle right after the accepting edge.
  task automatic send_word(input logic [15:0] w, input string tag);
    int k;
    @(posedge clk); #2;
    ifc.word_in    = w;
    ifc.word_valid = 1'b1;
    k = 0;
    while (!(ifc.word_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k == 0) @(negedge clk);
    check({tag, " accept"}, {31'd0, ifc.word_ready}, 32'd1);
    @(posedge clk); #2;
    ifc.word_valid = 1'b0;
    ifc.word_in    = 16'hDEAD;
  endtask

  // Wait for done/err events to reach target, bounded.
  task automatic wait_events(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while ((done_q.size() + err_q.size()) < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({tag, " event"}, {31'd0, (done_q.size() + err_q.size()) >= target}, 32'd1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic set_mode(input int m);
    @(posedge clk); #2;
    tx_mode = m;
    repeat (2) @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  int bw, bd, be, ba;

  initial begin
    checks = 0; failures = 0; both_cnt = 0; last_busy_cyc = 0;
    busy_left = 0; stuck_wrs = 0; cyc = 0;
    tx_mode = M_NORMAL;
    ifc.tx_busy = 1'b0;
    drive_idle();
    reset = 1'b0;
    #12;
    check("rst ready", {31'd0, ifc.word_ready}, 32'd1);
    check("rst tx_wr", {31'd0, ifc.tx_wr}, 32'd0);
    check("rst tx_data", {24'd0, ifc.tx_data}, 32'h00);
    check("rst done", {31'd0, ifc.done}, 32'd0);
    check("rst err", {31'd0, ifc.timeout_err}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // 1: normal word A55A
    bw = wr_data_q.size(); bd = done_q.size(); be = err_q.size(); ba = acc_q.size();
    send_word(16'hA55A, "t1");
    wait_events(done_q.size() + err_q.size() + 1, 300, "t1");
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    check_bytes("t1", bw);
    check("t1 latency", wr_cyc_q[bw] - acc_q[ba], 1);
    check("t1 gap", gap_q[bw + 1], GAP_CYCLES + 1);
    check("t1 done_lat", done_q[bd] - wr_cyc_q[bw + 1], 2 + BUSY_LEN);
    check("t1 ndone", done_q.size() - bd, 1);
    check("t1 nerr", err_q.size() - be, 0);

    // 2: busy held high at accept of 1234
    set_mode(M_HOLD);
    bw = wr_data_q.size(); bd = done_q.size();
    send_word(16'h1234, "t2");
    repeat (6) @(posedge clk);
    check("t2 no_wr_busy", wr_data_q.size() - bw, 0);
    #2 tx_mode = M_NORMAL;
    wait_events(done_q.size() + err_q.size() + 1, 300, "t2");
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    check_bytes("t2", bw);
    check("t2 ndone", done_q.size() - bd, 1);

    // 3: busy never rises -> ack timeout
    set_mode(M_NEVER);
    bw = wr_data_q.size(); bd = done_q.size(); be = err_q.size();
    send_word(16'hC33C, "t3");
    wait_events(done_q.size() + err_q.size() + 1, 100, "t3");
    check("t3 nerr", err_q.size() - be, 1);
    check("t3 ndone", done_q.size() - bd, 0);
    check("t3 nwr", wr_data_q.size() - bw, 1);
    if (err_q.size() > be && wr_data_q.size() > bw)
      check("t3 err_lat", err_q[be] - wr_cyc_q[bw], ACK_TIMEOUT);
    check("t3 ready_after", {31'd0, ifc.word_ready}, 32'd1);

    // 4: busy stuck after the low byte -> busy timeout
    set_mode(M_STUCK);
    bw = wr_data_q.size(); bd = done_q.size(); be = err_q.size();
    send_word(16'h4281, "t4");
    wait_events(done_q.size() + err_q.size() + 1, 300, "t4");
    check("t4 nerr", err_q.size() - be, 1);
    check("t4 ndone", done_q.size() - bd, 0);
    exp_q.push_back(8'h42); exp_q.push_back(8'h81);
    check_bytes("t4", bw);
    if (err_q.size() > be && wr_data_q.size() > bw + 1)
      check("t4 err_lat", err_q[be] - wr_cyc_q[bw + 1], 1 + BUSY_TIMEOUT);
    set_mode(M_NORMAL);

    // 5: reset during the gap of FF00
    bw = wr_data_q.size(); bd = done_q.size(); be = err_q.size();
    send_word(16'hFF00, "t5");
    repeat (16) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("t5 ready", {31'd0, ifc.word_ready}, 32'd1);
    check("t5 tx_data", {24'd0, ifc.tx_data}, 32'h00);
    check("t5 tx_wr", {31'd0, ifc.tx_wr}, 32'd0);
    check("t5 done", {31'd0, ifc.done}, 32'd0);
    check("t5 err", {31'd0, ifc.timeout_err}, 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    exp_q.push_back(8'hFF);
    check_bytes("t5", bw);
    check("t5 ndone", done_q.size() - bd, 0);
    check("t5 nerr", err_q.size() - be, 0);

    // 6: back-to-back words with valid held high
    bw = wr_data_q.size(); bd = done_q.size(); ba = acc_q.size();
    @(posedge clk); #2;
    ifc.word_in = 16'h0001;
    ifc.word_valid = 1'b1;
    begin
      int k;
      k = 0;
      while (acc_q.size() < ba + 1 && k < 50) begin @(posedge clk); k++; end
      #2 ifc.word_in = 16'h8000;
      k = 0;
      while (acc_q.size() < ba + 2 && k < 300) begin @(posedge clk); k++; end
      #2 ifc.word_valid = 1'b0;
      check("t6 two_accepts", acc_q.size() - ba, 2);
    end
    wait_events(done_q.size() + err_q.size() + 1, 300, "t6");
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    exp_q.push_back(8'h80); exp_q.push_back(8'h00);
    check_bytes("t6", bw);
    check("t6 ndone", done_q.size() - bd, 2);
    if (acc_q.size() > ba + 1 && done_q.size() > bd)
      check("t6 reaccept", acc_q[ba + 1] - done_q[bd], 1);

    check("done_err_excl", both_cnt, 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
